pipemem_arbiter: RTL and testbench
==================================

# pipemem_arbiter

Shares the pipeline's single-port data memory / memory-mapped I/O space between the CPU MEM stage and one secondary master (DMA/debug loader). CPU has fixed priority; a saturating wait counter gives the secondary master a guaranteed slot after `STARVE_LIMIT` blocked cycles, and the CPU is stalled for that cycle. Sits between the MEM stage and the data memory, driving the memory's address, write-data and write-enable inputs.

## Interface

Parameters:
- `STARVE_LIMIT`, default 4: blocked DMA cycles before a forced DMA slot. Legal range 1..15. The wait counter is 4 bits.

Ports:
- `clock`  in  1: pipeline clock; all registers rise-edge.
- `resetn`  in  1: asynchronous, active-low reset.
- `cpu_req`  in  1: MEM stage performs a load or store this cycle.
- `cpu_we`  in  1: store when 1, load when 0.
- `cpu_addr`  in  32: byte address.
- `cpu_wdata`  in  32: store data.
- `cpu_rdata`  out  32: load data, same cycle.
- `cpu_stall`  out  1: freeze the pipeline; the CPU access is not performed this cycle.
- `dma_req`  in  1: DMA access pending; held with its fields until `dma_ack`.
- `dma_we`  in  1: DMA write when 1.
- `dma_addr`  in  32: DMA byte address.
- `dma_wdata`  in  32: DMA write data.
- `dma_ack`  out  1: DMA access performed this cycle.
- `dma_rdata`  out  32: registered DMA read data.
- `dma_rvalid`  out  1: one-cycle pulse; `dma_rdata` is valid.
- `mem_we`  out  1: memory/I/O write enable. Downstream applies its own clock-phase gating.
- `mem_addr`  out  32: to memory/I/O decode.
- `mem_wdata`  out  32: to memory/I/O.
- `mem_rdata`  in  32: combinational read data for `mem_addr`.

## Operation

- Registers: `wait_cnt[3:0]`, `dma_last`, `dma_rdata[31:0]`, `dma_rvalid`. All reset to 0.
- The grant is combinational each cycle:
  - `dma_gnt = resetn & dma_req & (~cpu_req | (wait_cnt >= STARVE_LIMIT & ~dma_last))`.
- Outputs:
  - `cpu_stall = cpu_req & dma_gnt`.
  - `dma_ack = dma_gnt`.
- Memory mux:
  - When `dma_gnt` is 1: `mem_addr/mem_wdata/mem_we = dma_addr/dma_wdata/dma_we`.
  - Otherwise: `mem_addr/mem_wdata = cpu_addr/cpu_wdata` and `mem_we = cpu_req & cpu_we & resetn`.
- `cpu_rdata = mem_rdata` unconditionally. It is meaningful only when `cpu_req & ~cpu_stall`.
- `wait_cnt` next value:
  - 0 if `~dma_req` or `dma_gnt`.
  - Else `wait_cnt+1`, saturating at `STARVE_LIMIT`.
- `dma_last` next value = `dma_gnt & cpu_req`. This prevents back-to-back forced slots while the CPU is requesting. An idle CPU never blocks DMA.
- DMA read capture: if `dma_gnt & ~dma_we`, then `dma_rdata <= mem_rdata` and `dma_rvalid <= 1`. Otherwise `dma_rvalid <= 0` and `dma_rdata` holds.
- Write ordering: within one cycle exactly one master reaches memory. A stalled CPU store is retried by the held pipeline next cycle, after the DMA write, so a DMA write and a CPU store to the same address resolve DMA-first.

## Timing

- CPU access latency: 0 extra cycles when not stalled. A forced DMA slot costs exactly 1 stall cycle.
- DMA latency:
  - Write completes in the `dma_ack` cycle.
  - Read data appears one cycle after `dma_ack` (`dma_rvalid` high for one cycle).
  - Worst-case wait under continuous `cpu_req` is `STARVE_LIMIT` cycles; ack comes in cycle `STARVE_LIMIT+1` after `dma_req` rises.
- Steady contention (both requesting every cycle): DMA receives one slot every `STARVE_LIMIT+1` cycles.
- `dma_req` dropping before ack: `wait_cnt` clears next edge; no access occurs.
- Reset asserted mid-operation:
  - Registers clear immediately.
  - `dma_ack`, `cpu_stall`, `mem_we` are 0 while `resetn` = 0.
  - A read whose `dma_rvalid` was due is lost.
- Reset values:
  - `dma_rvalid`=0, `dma_rdata`=0, `dma_ack`=0, `cpu_stall`=0, `mem_we`=0.
  - `mem_addr/mem_wdata` follow `cpu_addr/cpu_wdata`.

## Test plan

- CPU only: `cpu_req`=1, `cpu_we`=1, `cpu_addr`=0x14, `cpu_wdata`=0xDEADBEEF; then a load from 0x14 → `mem_we`=1 in the store cycle, then `cpu_rdata`=0xDEADBEEF, `cpu_stall` never 1.
- DMA only: `cpu_req`=0, DMA write 0x55 to 0x20, then DMA read of 0x20 → `dma_ack` in the same cycle as each request; `dma_rvalid`=1 with `dma_rdata`=0x55 exactly one cycle after the read ack.
- Starvation, `STARVE_LIMIT`=4: `cpu_req`=1 continuously, `dma_req` rises at cycle 0 → `dma_ack` and `cpu_stall` both 1 at cycle 4 only, `wait_cnt` back to 0 at cycle 5.
- Continuous contention over 20 cycles → DMA acks at cycles 4, 9, 14, 19; never two consecutive acks; CPU is unstalled on all other cycles.
- Same-address conflict: stall cycle with DMA write 0x1111 to 0x8 while the CPU stores 0x2222 to 0x8; pipeline retries the store → final memory value 0x2222.
- Reset mid-read: assert `resetn`=0 in the cycle after a DMA read ack → `dma_rvalid` stays 0, `dma_rdata`=0, `mem_we`=0 for the whole reset interval; normal arbitration resumes after release.

Source files
------------

// File: rtl/pipemem_arbiter.sv
// pipemem_arbiter
//
// This block shares the single-port data memory / memory-mapped I/O space
// between the CPU MEM stage and one secondary master (DMA or debug loader).
// The CPU has fixed priority. While the CPU is requesting, a saturating wait
// counter lets a blocked DMA request take one forced slot after STARVE_LIMIT
// blocked cycles. The CPU is stalled for that one cycle.
//
// DMA handshake (valid/ready):
//   - dma_req is "valid". The master holds dma_req, dma_we, dma_addr and
//     dma_wdata stable until it sees dma_ack.
//   - dma_ack is "ready" and is combinational. A transfer occurs in every
//     cycle where dma_req and dma_ack are both high.
//   - Read data returns on dma_rdata one cycle later, qualified by a
//     one-cycle dma_rvalid pulse.
//
// Ports:
//   clock, resetn          : rising-edge clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata  : MEM-stage access request
//   cpu_rdata              : combinational load data (mem_rdata passthrough)
//   cpu_stall              : CPU access not performed this cycle; hold pipeline
//   dma_req/we/addr/wdata  : secondary master request, held until dma_ack
//   dma_ack                : DMA access performed this cycle
//   dma_rdata, dma_rvalid  : registered DMA read data and its one-cycle strobe
//   mem_we/addr/wdata      : to memory / I/O decode
//   mem_rdata              : combinational read data for mem_addr
module pipemem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_ack,
  output logic [31:0] dma_rdata,
  output logic        dma_rvalid,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] wait_cnt;
  logic       dma_last;
  logic       dma_gnt;

  // A forced slot is refused right after a DMA slot taken while the CPU was
  // requesting. This keeps the CPU from being stalled on two cycles in a row.
  // An idle CPU never blocks DMA.
  assign dma_gnt = resetn & dma_req &
                   (~cpu_req | ((wait_cnt >= LIMIT) & ~dma_last));

  assign cpu_stall = cpu_req & dma_gnt;
  assign dma_ack   = dma_gnt;
  assign cpu_rdata = mem_rdata;

  // Exactly one master reaches memory per cycle. A stalled CPU store is
  // replayed by the held pipeline next cycle, so same-address writes land
  // DMA-first.
  always_comb begin
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_we    = cpu_req & cpu_we & resetn;
    if (dma_gnt) begin
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
      mem_we    = dma_we;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wait_cnt   <= 4'd0;
      dma_last   <= 1'b0;
      dma_rdata  <= 32'd0;
      dma_rvalid <= 1'b0;
    end else begin
      if (!dma_req || dma_gnt) begin
        wait_cnt <= 4'd0;
      end else if (wait_cnt >= LIMIT) begin
        wait_cnt <= LIMIT;
      end else begin
        wait_cnt <= wait_cnt + 4'd1;
      end

      dma_last <= dma_gnt & cpu_req;

      if (dma_gnt && !dma_we) begin
        dma_rdata  <= mem_rdata;
        dma_rvalid <= 1'b1;
      end else begin
        dma_rvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pipemem_arbiter.sv
module tb_pipemem_arbiter;

  // ---------------- clock / reset ----------------
  logic        clock = 1'b0;
  logic        resetn;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        dma_req, dma_we;
  logic [31:0] dma_addr, dma_wdata;
  logic        dma_ack;
  logic [31:0] dma_rdata;
  logic        dma_rvalid;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clock = ~clock;

  pipemem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clock(clock), .resetn(resetn),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .dma_rvalid(dma_rvalid),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Behavioural single-port memory: combinational read, rising-edge write.
  logic [31:0] mem [0:255];
  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clock) begin
    if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Scoreboard: every dma_rvalid pulse consumes one expected read value.
  always @(negedge clock) begin
    if (resetn && dma_rvalid) begin
      if (exp_q.size() == 0) begin
        check("dma_rvalid_unexpected", 32'(dma_rvalid), 32'd0);
      end else begin
        check("dma_rdata", dma_rdata, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic sample();
    @(negedge clock);
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic cpu_drive(input logic req, input logic we,
                           input logic [31:0] addr, input logic [31:0] wdata);
    cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
  endtask

  task automatic dma_drive(input logic req, input logic we,
                           input logic [31:0] addr, input logic [31:0] wdata);
    dma_req = req; dma_we = we; dma_addr = addr; dma_wdata = wdata;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    int n_ack;
    logic got_ack;

    resetn = 1'b0;
    cpu_drive(1'b1, 1'b1, 32'h1234, 32'hCAFE0000);
    dma_drive(1'b1, 1'b1, 32'h40, 32'h77);

    // Reset values with both masters requesting.
    sample();
    check("rst_dma_rvalid", 32'(dma_rvalid), 32'd0);
    check("rst_dma_rdata",  dma_rdata,        32'd0);
    check("rst_dma_ack",    32'(dma_ack),     32'd0);
    check("rst_cpu_stall",  32'(cpu_stall),   32'd0);
    check("rst_mem_we",     32'(mem_we),      32'd0);
    check("rst_mem_addr",   mem_addr,         32'h1234);
    check("rst_mem_wdata",  mem_wdata,        32'hCAFE0000);
    next_cycle();
    resetn = 1'b1;
    cpu_drive(1'b0, 1'b0, 32'h0, 32'h0);
    dma_drive(1'b0, 1'b0, 32'h0, 32'h0);
    next_cycle();

    // CPU only: store then load of 0x14.
    cpu_drive(1'b1, 1'b1, 32'h14, 32'hDEADBEEF);
    sample();
    check("cpu_st_mem_we",   32'(mem_we),    32'd1);
    check("cpu_st_mem_addr", mem_addr,       32'h14);
    check("cpu_st_stall",    32'(cpu_stall), 32'd0);
    next_cycle();
    cpu_drive(1'b1, 1'b0, 32'h14, 32'h0);
    sample();
    check("cpu_ld_rdata",  cpu_rdata,       32'hDEADBEEF);
    check("cpu_ld_mem_we", 32'(mem_we),     32'd0);
    check("cpu_ld_stall",  32'(cpu_stall),  32'd0);
    next_cycle();

    // DMA only: write 0x55 to 0x20, then read it back.
    cpu_drive(1'b0, 1'b0, 32'h0, 32'h0);
    dma_drive(1'b1, 1'b1, 32'h20, 32'h55);
    sample();
    check("dma_wr_ack",    32'(dma_ack), 32'd1);
    check("dma_wr_mem_we", 32'(mem_we),  32'd1);
    check("dma_wr_addr",   mem_addr,     32'h20);
    next_cycle();
    dma_drive(1'b1, 1'b0, 32'h20, 32'h0);
    sample();
    check("dma_rd_ack",    32'(dma_ack), 32'd1);
    check("dma_rd_mem_we", 32'(mem_we),  32'd0);
    exp_q.push_back(32'h55);
    next_cycle();
    dma_drive(1'b0, 1'b0, 32'h0, 32'h0);
    sample();
    check("dma_rd_rvalid", 32'(dma_rvalid), 32'd1);
    next_cycle();
    sample();
    check("dma_rd_rvalid_pulse", 32'(dma_rvalid), 32'd0);
    next_cycle();

    // Continuous contention, 20 cycles: acks expected at cycles 4, 9, 14, 19.
    n_ack = 0;
    for (int c = 0; c < 20; c++) begin
      cpu_drive(1'b1, 1'b0, 32'h40, 32'h0);
      dma_drive(1'b1, 1'b1, 32'h80, 32'hA0 + 32'(n_ack));
      sample();
      check($sformatf("cont_ack_c%0d", c),   32'(dma_ack),   32'((c % 5) == 4));
      check($sformatf("cont_stall_c%0d", c), 32'(cpu_stall), 32'((c % 5) == 4));
      check($sformatf("cont_we_c%0d", c),    32'(mem_we),    32'((c % 5) == 4));
      if (c == 4) check("starve_wait_cnt_c4", 32'(dut.wait_cnt), 32'd4);
      if (c == 5) check("starve_wait_cnt_c5", 32'(dut.wait_cnt), 32'd0);
      if (dma_ack) n_ack++;
      next_cycle();
    end
    check("cont_n_ack", 32'(n_ack), 32'd4);

    // DMA request withdrawn before ack: counter clears, no access.
    dma_drive(1'b0, 1'b0, 32'h0, 32'h0);
    next_cycle();
    dma_drive(1'b1, 1'b1, 32'h84, 32'hBB);
    next_cycle();
    next_cycle();
    dma_drive(1'b0, 1'b1, 32'h84, 32'hBB);
    sample();
    check("drop_ack",      32'(dma_ack),       32'd0);
    check("drop_wait_cnt", 32'(dut.wait_cnt),  32'd2);
    next_cycle();
    sample();
    check("drop_wait_clr", 32'(dut.wait_cnt),  32'd0);
    next_cycle();

    // Same-address conflict: DMA writes 0x1111 to 0x8 while CPU stores 0x2222.
    got_ack = 1'b0;
    for (int c = 0; c < 10 && !got_ack; c++) begin
      cpu_drive(1'b1, 1'b1, 32'h8, 32'h2222);
      dma_drive(1'b1, 1'b1, 32'h8, 32'h1111);
      sample();
      if (dma_ack) begin
        got_ack = 1'b1;
        check("conf_stall", 32'(cpu_stall), 32'd1);
        check("conf_wdata", mem_wdata,      32'h1111);
      end
      next_cycle();
    end
    if (!got_ack) check("conf_ack_timeout", 32'(got_ack), 32'd1);
    // Held pipeline retries the stalled store.
    dma_drive(1'b0, 1'b0, 32'h0, 32'h0);
    cpu_drive(1'b1, 1'b1, 32'h8, 32'h2222);
    sample();
    check("conf_mem_after_dma", mem[2], 32'h1111);
    check("conf_retry_stall",   32'(cpu_stall), 32'd0);
    next_cycle();
    cpu_drive(1'b1, 1'b0, 32'h8, 32'h0);
    sample();
    check("conf_final", cpu_rdata, 32'h2222);
    next_cycle();

    // Reset in the cycle after a DMA read ack: the pending read is lost.
    cpu_drive(1'b0, 1'b0, 32'h0, 32'h0);
    dma_drive(1'b1, 1'b0, 32'h20, 32'h0);
    sample();
    check("rstrd_ack", 32'(dma_ack), 32'd1);
    next_cycle();
    resetn = 1'b0;
    cpu_drive(1'b1, 1'b1, 32'h30, 32'h3333);
    dma_drive(1'b1, 1'b1, 32'h34, 32'h4444);
    for (int c = 0; c < 3; c++) begin
      sample();
      check($sformatf("rstrd_rvalid_%0d", c), 32'(dma_rvalid), 32'd0);
      check($sformatf("rstrd_rdata_%0d", c),  dma_rdata,        32'd0);
      check($sformatf("rstrd_mem_we_%0d", c), 32'(mem_we),      32'd0);
      check($sformatf("rstrd_ack_%0d", c),    32'(dma_ack),     32'd0);
      check($sformatf("rstrd_stall_%0d", c),  32'(cpu_stall),   32'd0);
      next_cycle();
    end
    resetn = 1'b1;
    dma_drive(1'b0, 1'b0, 32'h0, 32'h0);
    sample();
    check("post_rst_mem_we", 32'(mem_we),    32'd1);
    check("post_rst_stall",  32'(cpu_stall), 32'd0);
    next_cycle();
    cpu_drive(1'b0, 1'b0, 32'h0, 32'h0);
    dma_drive(1'b1, 1'b0, 32'h14, 32'h0);
    sample();
    check("post_rst_dma_ack", 32'(dma_ack), 32'd1);
    exp_q.push_back(32'hDEADBEEF);
    next_cycle();
    dma_drive(1'b0, 1'b0, 32'h0, 32'h0);
    sample();
    check("post_rst_rvalid", 32'(dma_rvalid), 32'd1);
    next_cycle();
    sample();
    check("post_rst_mem_30", mem[12], 32'h3333);

    // ---------------- final report ----------------
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
